// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcode encodings, response payload and opcode support check.
package alu_pkg;

    localparam int unsigned ALU_N  = 4;
    localparam int unsigned SEL_W  = 4;
    localparam int unsigned RESP_W = ALU_N + 4;

    typedef enum logic [SEL_W-1:0] {
        OP_AND = 4'b0000,
        OP_OR  = 4'b0001,
        OP_XOR = 4'b0010,
        OP_ADD = 4'b0011,
        OP_SL  = 4'b0100,
        OP_SR  = 4'b0101,
        OP_SUB = 4'b0110
    } alu_op_e;

    // Packed so it lines up with {result, OF, carry_, cero, neg}.
    typedef struct packed {
        logic [ALU_N-1:0] result;
        logic             ovf;
        logic             carry_;
        logic             cero;
        logic             neg;
    } alu_resp_t;

    // Opcodes above SUB have no reference behaviour and are skipped.
    function automatic logic is_supported(input logic [SEL_W-1:0] sel);
        return (sel <= SEL_W'(OP_SUB));
    endfunction

endpackage

// File: rtl/alu_ref_model.sv
// Combinational ALU reference: (a, b, sel) -> expected response.
// ALU_CHECK_FLAGS_EN: when undefined only the result is modelled, flags read 0.
module alu_ref_model
    import alu_pkg::*;
(
    input  logic [ALU_N-1:0] a,
    input  logic [ALU_N-1:0] b,
    input  logic [SEL_W-1:0] sel,
    output alu_resp_t        resp
);

`ifdef ALU_CHECK_FLAGS_EN
    logic [ALU_N:0] sum_c;
    logic [ALU_N:0] dif_c;

    // Widened add/subtract so the carry out of bit N-1 is available.
    always_comb begin
        sum_c = {1'b0, a} + {1'b0, b};
        dif_c = {1'b0, a} + {1'b0, ~b} + (ALU_N + 1)'(1);
    end
`endif

    // Expected result per opcode, then zero/negative derived from it.
    always_comb begin
        resp = '0;
        case (sel)
            OP_AND: resp.result = a & b;
            OP_OR:  resp.result = a | b;
            OP_XOR: resp.result = a ^ b;
`ifdef ALU_CHECK_FLAGS_EN
            OP_ADD: begin
                resp.result = sum_c[ALU_N-1:0];
                resp.carry_ = sum_c[ALU_N];
                resp.ovf    = (a[ALU_N-1] == b[ALU_N-1]) && (sum_c[ALU_N-1] != a[ALU_N-1]);
            end
            OP_SUB: begin
                resp.result = dif_c[ALU_N-1:0];
                resp.carry_ = dif_c[ALU_N];
                resp.ovf    = (a[ALU_N-1] != b[ALU_N-1]) && (dif_c[ALU_N-1] != a[ALU_N-1]);
            end
`else
            OP_ADD: resp.result = a + b;
            OP_SUB: resp.result = a - b;
`endif
            OP_SL:  resp.result = (32'(b) >= ALU_N) ? '0 : (a << b);
            OP_SR:  resp.result = (32'(b) >= ALU_N) ? '0 : (a >> b);
            default: resp = '0;
        endcase
`ifdef ALU_CHECK_FLAGS_EN
        resp.cero = (resp.result == '0);
        resp.neg  = resp.result[ALU_N-1];
`endif
    end

endmodule

// File: rtl/alu_checker.sv
// In-system ALU response checker: two-stage sample/compare pipeline, FSM,
// saturating pass/fail/skip counters and first-mismatch capture.
// ALU_CHECK_FLAGS_EN: defined compares result and flags; undefined compares result only.
module alu_checker
    import alu_pkg::*;
#(
    parameter int unsigned N     = ALU_N,
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             stop_on_err,
    input  logic             chk_valid,
    output logic             chk_ready,
    input  logic [N-1:0]     A,
    input  logic [N-1:0]     B,
    input  logic [3:0]       sel,
    input  logic [N-1:0]     result,
    input  logic             OF,
    input  logic             carry_,
    input  logic             cero,
    input  logic             neg,
    output logic             mismatch,
    output logic             err,
    output logic [3:0]       err_sel,
    output logic [N+3:0]     err_exp,
    output logic [N+3:0]     err_got,
    output logic [CNT_W-1:0] pass_cnt,
    output logic [CNT_W-1:0] fail_cnt,
    output logic [CNT_W-1:0] skip_cnt,
    output logic             halted
);

    typedef enum logic [1:0] {ST_IDLE, ST_ARMED, ST_HALT} state_e;

    state_e             state_q, state_d;
    logic               chk_ready_q, chk_ready_d;
    logic               halted_q, halted_d;
    logic               s1_valid_q, s1_valid_d;
    logic [ALU_N-1:0]   s1_a_q, s1_a_d, s1_b_q, s1_b_d;
    logic [SEL_W-1:0]   s1_sel_q, s1_sel_d;
    alu_resp_t          s1_obs_q, s1_obs_d;
    logic               mismatch_q, mismatch_d;
    logic               err_q, err_d;
    logic [SEL_W-1:0]   err_sel_q, err_sel_d;
    alu_resp_t          err_exp_q, err_exp_d, err_got_q, err_got_d;
    logic [CNT_W-1:0]   pass_q, pass_d, fail_q, fail_d, skip_q, skip_d;

    alu_resp_t          obs_c, exp_c;
    logic               accept_c, supp_c, fail_c, pass_c, skip_c;

`ifdef ALU_CHECK_FLAGS_EN
    assign obs_c = alu_resp_t'({result, OF, carry_, cero, neg});
`else
    logic unused_flags;
    assign unused_flags = ^{OF, carry_, cero, neg};
    assign obs_c = alu_resp_t'({result, 4'b0000});
`endif

    alu_ref_model u_ref (
        .a    (s1_a_q),
        .b    (s1_b_q),
        .sel  (s1_sel_q),
        .resp (exp_c)
    );

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == '1) ? v : v + CNT_W'(1);
    endfunction

    // Accept/compare qualifiers; start drops any coincident sample.
    always_comb begin
        accept_c = chk_valid && chk_ready_q && !start;
        supp_c   = is_supported(s1_sel_q);
        fail_c   = s1_valid_q && supp_c && (exp_c != s1_obs_q);
        pass_c   = s1_valid_q && supp_c && (exp_c == s1_obs_q);
        skip_c   = s1_valid_q && !supp_c;
    end

    // Next state: start always re-arms; a failing check with stop_on_err halts.
    always_comb begin
        state_d = state_q;
        if (start) begin
            state_d = ST_ARMED;
        end else if ((state_q == ST_ARMED) && fail_c && stop_on_err) begin
            state_d = ST_HALT;
        end
        chk_ready_d = (state_d == ST_ARMED);
        halted_d    = (state_d == ST_HALT);
    end

    // State and handshake status registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            chk_ready_q <= 1'b0;
            halted_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            chk_ready_q <= chk_ready_d;
            halted_q    <= halted_d;
        end
    end

    // Sample capture, compare outcome, counters and first-mismatch capture.
    always_comb begin
        s1_valid_d = accept_c;
        s1_a_d     = s1_a_q;
        s1_b_d     = s1_b_q;
        s1_sel_d   = s1_sel_q;
        s1_obs_d   = s1_obs_q;
        mismatch_d = 1'b0;
        err_d      = err_q;
        err_sel_d  = err_sel_q;
        err_exp_d  = err_exp_q;
        err_got_d  = err_got_q;
        pass_d     = pass_q;
        fail_d     = fail_q;
        skip_d     = skip_q;
        if (accept_c) begin
            s1_a_d   = ALU_N'(A);
            s1_b_d   = ALU_N'(B);
            s1_sel_d = sel;
            s1_obs_d = obs_c;
        end
        if (start) begin
            err_d     = 1'b0;
            err_sel_d = '0;
            err_exp_d = '0;
            err_got_d = '0;
            pass_d    = '0;
            fail_d    = '0;
            skip_d    = '0;
        end else begin
            mismatch_d = fail_c;
            if (pass_c) pass_d = sat_inc(pass_q);
            if (fail_c) fail_d = sat_inc(fail_q);
            if (skip_c) skip_d = sat_inc(skip_q);
            if (fail_c && !err_q) begin
                err_d     = 1'b1;
                err_sel_d = s1_sel_q;
                err_exp_d = exp_c;
                err_got_d = s1_obs_q;
            end
        end
    end

    // Datapath registers; reset discards anything in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s1_a_q     <= '0;
            s1_b_q     <= '0;
            s1_sel_q   <= '0;
            s1_obs_q   <= '0;
            mismatch_q <= 1'b0;
            err_q      <= 1'b0;
            err_sel_q  <= '0;
            err_exp_q  <= '0;
            err_got_q  <= '0;
            pass_q     <= '0;
            fail_q     <= '0;
            skip_q     <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_a_q     <= s1_a_d;
            s1_b_q     <= s1_b_d;
            s1_sel_q   <= s1_sel_d;
            s1_obs_q   <= s1_obs_d;
            mismatch_q <= mismatch_d;
            err_q      <= err_d;
            err_sel_q  <= err_sel_d;
            err_exp_q  <= err_exp_d;
            err_got_q  <= err_got_d;
            pass_q     <= pass_d;
            fail_q     <= fail_d;
            skip_q     <= skip_d;
        end
    end

    assign chk_ready = chk_ready_q;
    assign halted    = halted_q;
    assign mismatch  = mismatch_q;
    assign err       = err_q;
    assign err_sel   = err_sel_q;
    assign err_exp   = (N + 4)'(err_exp_q);
    assign err_got   = (N + 4)'(err_got_q);
    assign pass_cnt  = pass_q;
    assign fail_cnt  = fail_q;
    assign skip_cnt  = skip_q;

endmodule

// File: doc/alu_checker.md
# alu_checker

Synthesizable in-system monitor that sits on the ALU's output side: it samples ALU operands, opcode and the ALU's reported result/flags on a strobe, recomputes the expected response with an internal reference model, and compares the two. It keeps saturating pass/fail/skip counters, a sticky error flag and a capture of the first mismatch. It is the receiving and checking end of the ALU stimulus path, used on FPGA bring-up alongside the stimulus driver.

## Interface
- N, 4, ALU operand/result width
- CNT_W, 8, width of each statistics counter

- clk  in  1  system clock
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  clears counters and error capture; arms checker
- stop_on_err  in  1  1 = halt on first mismatch
- chk_valid  in  1  sample strobe; one check per cycle high
- chk_ready  out  1  checker accepts samples (high only in ARMED)
- A, B  in  N  operands driven to the ALU
- sel  in  4  ALU opcode
- result  in  N  ALU result
- OF, carry_, cero, neg  in  1 each  ALU flags
- mismatch  out  1  one-cycle pulse per failed check
- err  out  1  sticky, set on first mismatch
- err_sel  out  4  opcode of first mismatch
- err_exp, err_got  out  N+4  {result, OF, carry_, cero, neg} expected vs. observed, first mismatch
- pass_cnt, fail_cnt, skip_cnt  out  CNT_W each  saturating counters
- halted  out  1  high in HALT

## Operation
- Opcodes: 0000 AND, 0001 OR, 0010 XOR, 0011 ADD, 0100 SL (A<<B), 0101 SR logical (A>>B), 0110 SUB (A-B). 0111–1111 are unsupported; they increment skip_cnt and are not compared.
- Arithmetic is modulo 2^N. ADD carry_ = carry out of bit N-1. SUB carry_ = carry out of A+~B+1, so 1 means no borrow.
- OF is signed two's-complement overflow for ADD/SUB and 0 otherwise. carry_ = 0 for logic ops and shifts.
- Shifts with B ≥ N give result 0.
- cero = (result==0) and neg = result[N-1], computed on the expected result for all supported ops.
- FSM states:
  - IDLE (reset state): samples ignored. start → ARMED.
  - ARMED: every chk_valid sample is checked.
  - Mismatch with stop_on_err=1 → HALT.
  - HALT: samples ignored, chk_ready=0. start → ARMED.
  - start in any state → ARMED with counters and capture cleared.
- Simultaneous start and chk_valid: start wins and the sample is dropped.
- Samples still in the pipeline when HALT is entered complete their check and update counters.
- Only the first mismatch after start updates err_sel/err_exp/err_got. Later mismatches only pulse mismatch and increment fail_cnt.
- Counters saturate at 2^CNT_W-1.

## Timing
- Reset values:
  - all outputs 0, except chk_ready=0 and halted=0
  - state IDLE
  - pipeline valid bits cleared, so in-flight samples are discarded and never counted.
- Stage 1: the sample (A, B, sel, result, flags) is registered at the edge where chk_valid && chk_ready.
- Stage 2: expected vs. observed compare is registered at the following edge.
- mismatch, counter updates and error capture are visible 2 edges after sample acceptance. Throughput is 1 sample/cycle.
- After the first mismatch with stop_on_err=1, chk_ready falls on the same edge that asserts mismatch. Samples accepted one cycle earlier still complete.
- start takes effect at the next edge: counters read 0 and chk_ready=1 one cycle after start.

## Configuration
- ALU_CHECK_FLAGS_EN defined: the compare covers result and all four flags.
- ALU_CHECK_FLAGS_EN undefined: only result is compared. The flag fields of err_exp/err_got are driven 0, and the flag logic in the reference model is removed.

## Structure
- Package alu_pkg holds:
  - the opcode enum alu_op_e (encodings above)
  - the struct alu_resp_t {result, OF, carry_, cero, neg}
  - the function is_supported(sel).
- Sub-module alu_ref_model: purely combinational (A, B, sel) → alu_resp_t. It is reusable by other benches.
- The top level holds the FSM, the two pipeline stages, the counters and the capture registers.

## Test plan
- AND, A=1010 B=1100, result=1000, neg=1, other flags 0 → pass_cnt=1 two edges later, mismatch=0.
- ADD, A=0111 B=0001, result=1000, OF observed 0 (expected 1) → mismatch pulse, fail_cnt=1, err=1, err_sel=0011, err_exp flags OF=1 neg=1. With ALU_CHECK_FLAGS_EN undefined → counts as a pass.
- sel=1001, any data → skip_cnt=1, pass_cnt and fail_cnt unchanged.
- stop_on_err=1, bad SR sample (A=1000 B=0010, result=0001 vs. expected 0010) → halted=1, chk_ready=0, following valid samples not counted. Then start → counters 0, chk_ready=1.
- Back-to-back 3 samples, then rst_n pulsed low while 2 are in flight → all outputs 0, state IDLE, no counter change after rst_n rises.
- 260 consecutive failing samples with stop_on_err=0 → fail_cnt holds at 255; err_got equals the first failure only.
